// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared encodings for the CPU-side SRAM port arbiter: FSM states and port owner.
package cpu_sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_INST = 1'b0,
        ARB_OWNER_DATA = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/cpu_sram_arbiter.sv
// Shares one SRAM-like slave port between instruction fetch and data access:
// data has priority, a starvation counter forces an instruction grant.
module cpu_sram_arbiter
    import cpu_sram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e       state_q, state_d;
    arb_owner_e       owner_q, owner_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    arb_owner_e grant;
    logic       req_c;
    logic       handshake;
    logic       done;

    // NOTE: every signal written below gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        grant        = owner_q;
        req_c        = 1'b0;
        handshake    = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (inst_req && (starve_cnt_q == CNT_MAX)) grant = ARB_OWNER_INST;
                else if (data_req)                          grant = ARB_OWNER_DATA;
                else                                        grant = ARB_OWNER_INST;
                req_c = inst_req | data_req;
                if (req_c) begin
                    owner_d   = grant;
                    handshake = s_addr_ok;
                    state_d   = s_addr_ok ? ARB_DATA : ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                req_c = 1'b1;
                if (s_addr_ok) begin
                    handshake = 1'b1;
                    state_d   = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (s_data_ok) begin
                    done    = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Starvation bookkeeping happens only when an address is actually accepted.
        if (handshake) begin
            if (grant == ARB_OWNER_INST) begin
                starve_cnt_d = '0;
            end else if (inst_req && (starve_cnt_q != CNT_MAX)) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ARB_IDLE;
            owner_q      <= ARB_OWNER_INST;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Handshakes are gated by resetn so nothing leaks out while reset is asserted.
    assign s_req        = resetn & req_c;
    assign inst_addr_ok = resetn & handshake & (grant == ARB_OWNER_INST);
    assign data_addr_ok = resetn & handshake & (grant == ARB_OWNER_DATA);
    assign inst_data_ok = resetn & done & (owner_q == ARB_OWNER_INST);
    assign data_data_ok = resetn & done & (owner_q == ARB_OWNER_DATA);

    assign s_wr    = (grant == ARB_OWNER_DATA) ? data_wr    : inst_wr;
    assign s_size  = (grant == ARB_OWNER_DATA) ? data_size  : inst_size;
    assign s_addr  = (grant == ARB_OWNER_DATA) ? data_addr  : inst_addr;
    assign s_wdata = (grant == ARB_OWNER_DATA) ? data_wdata : inst_wdata;

    assign inst_rdata = s_rdata;
    assign data_rdata = s_rdata;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed and randomized checks of cpu_sram_arbiter against a transaction-level
// model of its grant priority and starvation rule.
module tb_cpu_sram_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_sram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled 1ns later, well before the next edge.
    initial begin
        bit          ip, dp, win_data, dwr;
        logic [31:0] ia, da, dw, rd;
        logic [1:0]  isz, dsz;
        int          starve, d, e;

        clear_inputs();
        resetn   = 1'b0;
        inst_req = 1'b1;
        data_req = 1'b1;
        s_addr_ok = 1'b1;
        #2;
        check("rst_s_req", s_req, 0);
        check("rst_inst_addr_ok", inst_addr_ok, 0);
        check("rst_data_addr_ok", data_addr_ok, 0);
        tick();
        tick();
        clear_inputs();
        resetn = 1'b1;

        // Single read
        data_req = 1'b1; data_addr = 32'h0000_1000; s_addr_ok = 1'b1;
        #1;
        check("rd_s_req", s_req, 1);
        check("rd_s_addr", s_addr, 32'h0000_1000);
        check("rd_data_addr_ok", data_addr_ok, 1);
        check("rd_inst_addr_ok", inst_addr_ok, 0);
        tick();
        data_req = 1'b0; s_addr_ok = 1'b0;
        #1;
        check("rd_wait_s_req", s_req, 0);
        check("rd_wait_data_ok", data_data_ok, 0);
        tick();
        s_data_ok = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        check("rd_data_ok", data_data_ok, 1);
        check("rd_rdata", data_rdata, 32'hDEAD_BEEF);
        check("rd_inst_data_ok", inst_data_ok, 0);
        tick();

        // Stray s_data_ok in IDLE, then prove the FSM still grants immediately
        s_data_ok = 1'b1;
        #1;
        check("stray_inst_data_ok", inst_data_ok, 0);
        check("stray_data_data_ok", data_data_ok, 0);
        check("stray_s_req", s_req, 0);
        tick();
        s_data_ok = 1'b0;

        // Simultaneous requests: data first
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        data_req = 1'b1; data_addr = 32'h0000_2000;
        s_addr_ok = 1'b1;
        #1;
        check("sim_s_addr", s_addr, 32'h0000_2000);
        check("sim_data_addr_ok", data_addr_ok, 1);
        check("sim_inst_addr_ok", inst_addr_ok, 0);
        tick();
        data_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h1111_1111;
        #1;
        check("sim_data_data_ok", data_data_ok, 1);
        check("sim_inst_data_ok", inst_data_ok, 0);
        tick();
        s_data_ok = 1'b0;

        // Inst granted in the next IDLE cycle, then grant lock while s_addr_ok stays low
        #1;
        check("lock0_s_req", s_req, 1);
        check("lock0_s_addr", s_addr, 32'hBFC0_0000);
        check("lock0_inst_addr_ok", inst_addr_ok, 0);
        tick();
        data_req = 1'b1; data_addr = 32'h0000_3000;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("lock_s_req", s_req, 1);
            check("lock_s_addr", s_addr, 32'hBFC0_0000);
            check("lock_data_addr_ok", data_addr_ok, 0);
            tick();
        end
        s_addr_ok = 1'b1;
        #1;
        check("lock_inst_addr_ok", inst_addr_ok, 1);
        check("lock_data_addr_ok_hs", data_addr_ok, 0);
        check("lock_s_addr_hs", s_addr, 32'hBFC0_0000);
        tick();
        inst_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h2222_2222;
        #1;
        check("lock_inst_data_ok", inst_data_ok, 1);
        check("lock_data_data_ok", data_data_ok, 0);
        check("lock_inst_rdata", inst_rdata, 32'h2222_2222);
        tick();
        s_data_ok = 1'b0;

        // Starvation: both held high, expect D D D D I repeating
        inst_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            win_data = ((k % 5) != 4);
            s_addr_ok = 1'b1;
            #1;
            check("stv_s_addr", s_addr, win_data ? 32'h0000_3000 : 32'hBFC0_0000);
            check("stv_data_addr_ok", data_addr_ok, 32'(win_data));
            check("stv_inst_addr_ok", inst_addr_ok, 32'(!win_data));
            tick();
            s_addr_ok = 1'b0; s_data_ok = 1'b1;
            #1;
            check("stv_data_data_ok", data_data_ok, 32'(win_data));
            check("stv_inst_data_ok", inst_data_ok, 32'(!win_data));
            tick();
            s_data_ok = 1'b0;
        end

        // Reset in DATA: late s_data_ok must be dropped
        data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0008; s_addr_ok = 1'b1;
        #1;
        check("rmo_inst_addr_ok", inst_addr_ok, 1);
        tick();
        inst_req = 1'b0; s_addr_ok = 1'b0;
        resetn = 1'b0;
        s_data_ok = 1'b1;
        #1;
        check("rmo_in_rst_inst_data_ok", inst_data_ok, 0);
        check("rmo_in_rst_s_req", s_req, 0);
        tick();
        resetn = 1'b1;
        #1;
        check("rmo_late_inst_data_ok", inst_data_ok, 0);
        check("rmo_late_data_data_ok", data_data_ok, 0);
        check("rmo_late_s_req", s_req, 0);
        tick();
        s_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0010; s_addr_ok = 1'b1;
        #1;
        check("rmo_next_inst_addr_ok", inst_addr_ok, 1);
        check("rmo_next_s_addr", s_addr, 32'hBFC0_0010);
        tick();
        inst_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
        #1;
        check("rmo_next_inst_data_ok", inst_data_ok, 1);
        tick();
        s_data_ok = 1'b0;

        // Randomized transactions against a transaction-level priority model
        ip = 1'b0; dp = 1'b0; starve = 0;
        ia = '0; da = '0; dw = '0; isz = '0; dsz = '0; dwr = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (!ip && ($urandom % 2 == 1)) begin
                ip = 1'b1; ia = $urandom; isz = 2'($urandom);
            end
            if (!dp && ($urandom % 2 == 1)) begin
                dp = 1'b1; da = $urandom; dw = $urandom; dsz = 2'($urandom); dwr = 1'($urandom);
            end
            if (!ip && !dp) begin
                dp = 1'b1; da = $urandom; dw = $urandom; dsz = 2'($urandom); dwr = 1'($urandom);
            end
            win_data = dp && !(ip && starve == STARVE_MAX);
            inst_req = ip; inst_addr = ia; inst_size = isz; inst_wdata = $urandom;
            data_req = dp; data_addr = da; data_size = dsz; data_wdata = dw; data_wr = dwr;

            d = int'($urandom_range(2, 0));
            for (int c = 0; c <= d; c++) begin
                s_addr_ok = (c == d);
                s_data_ok = 1'($urandom);
                s_rdata   = $urandom;
                #1;
                check("rnd_s_req", s_req, 1);
                check("rnd_s_addr", s_addr, win_data ? da : ia);
                check("rnd_s_wr", s_wr, win_data ? 32'(dwr) : 0);
                check("rnd_s_size", s_size, win_data ? 32'(dsz) : 32'(isz));
                check("rnd_s_wdata", s_wdata, win_data ? dw : inst_wdata);
                check("rnd_inst_addr_ok", inst_addr_ok, 32'((c == d) && !win_data));
                check("rnd_data_addr_ok", data_addr_ok, 32'((c == d) && win_data));
                check("rnd_a_inst_data_ok", inst_data_ok, 0);
                check("rnd_a_data_data_ok", data_data_ok, 0);
                tick();
            end

            if (win_data) begin
                if (ip && starve < STARVE_MAX) starve++;
                dp = 1'b0;
            end else begin
                starve = 0;
                ip = 1'b0;
            end
            inst_req = ip;
            data_req = dp;

            e = int'($urandom_range(2, 0));
            for (int c = 0; c <= e; c++) begin
                s_addr_ok = 1'($urandom);
                s_data_ok = (c == e);
                rd = $urandom;
                s_rdata = rd;
                #1;
                check("rnd_d_s_req", s_req, 0);
                check("rnd_d_inst_addr_ok", inst_addr_ok, 0);
                check("rnd_d_data_addr_ok", data_addr_ok, 0);
                check("rnd_inst_data_ok", inst_data_ok, 32'((c == e) && !win_data));
                check("rnd_data_data_ok", data_data_ok, 32'((c == e) && win_data));
                if (c == e) begin
                    check("rnd_inst_rdata", inst_rdata, rd);
                    check("rnd_data_rdata", data_rdata, rd);
                end
                tick();
            end
            s_addr_ok = 1'b0;
            s_data_ok = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
